// File: rtl/nts_rx_sequencer.sv
// Receive sequencer: buffers one MAC frame in block RAM, then replays it to the
// parser (clear, word stream, process strobes) and holds it until released.
module nts_rx_sequencer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_mac_valid,
    input  logic [63:0]           i_mac_data,
    input  logic                  i_mac_last,
    input  logic [7:0]            i_mac_bytes_valid,
    input  logic                  i_mac_bad,
    input  logic                  i_release,
    output logic                  o_clear,
    output logic                  o_process,
    output logic [63:0]           o_data,
    output logic [7:0]            o_last_word_data_valid,
    output logic                  o_frame_valid,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic [31:0]           o_drop_count
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_DROP,
        ST_CLEAR,
        ST_PLAYOUT,
        ST_HOLD
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH:0]     count_reg, count_next;
    logic [7:0]              mask_reg, mask_next;
    logic [ADDR_WIDTH-1:0]   play_idx_reg, play_idx_next;
    logic                    mid_frame_reg, mid_frame_next;
    logic [31:0]             drop_count_reg;
    logic                    process_reg;
    logic [63:0]             data_reg;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    drop_inc;

    logic [63:0] mem [DEPTH];

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        mask_next      = mask_reg;
        play_idx_next  = play_idx_reg;
        mid_frame_next = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = count_reg[ADDR_WIDTH-1:0];
        rd_en          = 1'b0;
        rd_addr        = play_idx_reg + IDX_ONE;
        drop_inc       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_mac_valid) begin
                    if (i_mac_last && i_mac_bad) begin
                        drop_inc = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        count_next = CNT_ONE;
                        if (i_mac_last) begin
                            mask_next  = i_mac_bytes_valid;
                            state_next = ST_CLEAR;
                        end else begin
                            state_next = ST_RECEIVE;
                        end
                    end
                end
            end
            ST_RECEIVE: begin
                if (i_mac_valid) begin
                    // Buffer already full: this beat would wrap the address, so the frame is lost.
                    if (count_reg == FULL) begin
                        if (i_mac_last) begin
                            drop_inc   = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_DROP;
                        end
                    end else if (i_mac_last && i_mac_bad) begin
                        drop_inc   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        wr_en      = 1'b1;
                        count_next = count_reg + CNT_ONE;
                        if (i_mac_last) begin
                            mask_next  = i_mac_bytes_valid;
                            state_next = ST_CLEAR;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (i_mac_valid && i_mac_last) begin
                    drop_inc   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                rd_en         = 1'b1;
                rd_addr       = '0;
                play_idx_next = '0;
                state_next    = ST_PLAYOUT;
            end
            ST_PLAYOUT: begin
                if (({1'b0, play_idx_reg} + CNT_ONE) == count_reg) begin
                    state_next = ST_HOLD;
                end else begin
                    rd_en         = 1'b1;
                    play_idx_next = play_idx_reg + IDX_ONE;
                end
            end
            ST_HOLD: begin
                // Release is honoured only once the last process strobe has gone out.
                if (i_release && !process_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A frame arriving while the buffer is busy is discarded and counted at its last beat.
        if (state_reg == ST_CLEAR || state_reg == ST_PLAYOUT || state_reg == ST_HOLD) begin
            mid_frame_next = i_mac_valid ? !i_mac_last : mid_frame_reg;
            if (i_mac_valid && i_mac_last) begin
                drop_inc = 1'b1;
            end
            if (state_reg == ST_HOLD && state_next == ST_IDLE && mid_frame_next) begin
                state_next = ST_DROP;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            mask_reg       <= '0;
            play_idx_reg   <= '0;
            mid_frame_reg  <= 1'b0;
            drop_count_reg <= '0;
            process_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            mask_reg       <= mask_next;
            play_idx_reg   <= play_idx_next;
            mid_frame_reg  <= mid_frame_next;
            drop_count_reg <= drop_count_reg + (drop_inc ? 32'd1 : 32'd0);
            process_reg    <= (state_reg == ST_PLAYOUT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= i_mac_data;
        end
    end

    // Registered read; holds the final word after playout stops reading.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            data_reg <= '0;
        end else if (rd_en) begin
            data_reg <= mem[rd_addr];
        end
    end

    assign o_clear                = (state_reg == ST_CLEAR);
    assign o_process              = process_reg;
    assign o_data                 = data_reg;
    assign o_last_word_data_valid = mask_reg;
    assign o_frame_valid          = (state_reg == ST_HOLD) && !process_reg;
    assign o_word_count           = count_reg;
    assign o_drop_count           = drop_count_reg;

endmodule

// File: tb/tb_nts_rx_sequencer.sv
// Self-checking bench for nts_rx_sequencer: scoreboard of buffered words checked
// against the playout stream, plus per-scenario checks of counts and flags.
module tb_nts_rx_sequencer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic          mac_valid;
    logic [63:0]   mac_data;
    logic          mac_last;
    logic [7:0]    mac_bytes;
    logic          mac_bad;
    logic          release_i;
    logic          o_clear;
    logic          o_process;
    logic [63:0]   o_data;
    logic [7:0]    o_mask;
    logic          o_frame_valid;
    logic [AW:0]   o_word_count;
    logic [31:0]   o_drop_count;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            clear_cnt = 0;
    int            proc_cnt = 0;
    logic [63:0]   exp_q[$];
    logic [63:0]   prev_data = '0;
    logic [63:0]   last_sent = '0;
    logic [31:0]   exp_drop = '0;

    always #5 clk = ~clk;

    nts_rx_sequencer #(.ADDR_WIDTH(AW)) dut (
        .i_clk                  (clk),
        .i_areset               (areset),
        .i_mac_valid            (mac_valid),
        .i_mac_data             (mac_data),
        .i_mac_last             (mac_last),
        .i_mac_bytes_valid      (mac_bytes),
        .i_mac_bad              (mac_bad),
        .i_release              (release_i),
        .o_clear                (o_clear),
        .o_process              (o_process),
        .o_data                 (o_data),
        .o_last_word_data_valid (o_mask),
        .o_frame_valid          (o_frame_valid),
        .o_word_count           (o_word_count),
        .o_drop_count           (o_drop_count)
    );

    task automatic send_frame(input int n, input logic [7:0] mask, input bit bad,
                              input bit accept, input bit gaps);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w         = {$urandom, $urandom};
            mac_valid = 1'b1;
            mac_data  = w;
            mac_last  = (i == n - 1);
            mac_bytes = (i == n - 1) ? mask : 8'($urandom);
            mac_bad   = (i == n - 1) && bad;
            if (accept) exp_q.push_back(w);
            last_sent = w;
            @(posedge clk); #1;
            mac_valid = 1'b0;
            mac_last  = 1'b0;
            mac_bad   = 1'b0;
            mac_data  = {$urandom, $urandom};
            if (gaps && i != n - 1 && (i % 3) == 1) begin
                @(posedge clk); #1;
            end
        end
        $display("frame: %0d beats mask=%h bad=%0d expect_accept=%0d", n, mask, bad, accept);
    endtask

    task automatic wait_hold(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_frame();
        release_i = 1'b1;
        @(posedge clk); #1;
        release_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        #12;
        n_cmp += 7;
        if (o_clear !== 1'b0) begin n_bad++; $display("FAIL reset_clear: got %b want 0", o_clear); end
        if (o_process !== 1'b0) begin n_bad++; $display("FAIL reset_process: got %b want 0", o_process); end
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_frame_valid: got %b want 0", o_frame_valid); end
        if (o_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", o_data); end
        if (o_mask !== 8'h0) begin n_bad++; $display("FAIL reset_mask: got %h want 0", o_mask); end
        if (o_word_count !== '0) begin n_bad++; $display("FAIL reset_word_count: got %0d want 0", o_word_count); end
        if (o_drop_count !== 32'h0) begin n_bad++; $display("FAIL reset_drop_count: got %0d want 0", o_drop_count); end
        areset = 1'b0;
        idle(2);
        $display("reset: outputs checked");
    endtask

    task automatic test_good_frame();
        bit ok;
        clear_cnt = 0; proc_cnt = 0;
        send_frame(12, 8'hC0, 1'b0, 1'b1, 1'b1);
        wait_hold(ok);
        n_cmp += 6;
        if (!ok) begin n_bad++; $display("FAIL good_timeout: got no frame_valid want frame_valid"); end
        if (clear_cnt !== 1) begin n_bad++; $display("FAIL good_clear_cycles: got %0d want 1", clear_cnt); end
        if (proc_cnt !== 12) begin n_bad++; $display("FAIL good_process_cycles: got %0d want 12", proc_cnt); end
        if (o_word_count !== 5'd12) begin n_bad++; $display("FAIL good_word_count: got %0d want 12", o_word_count); end
        if (o_mask !== 8'hC0) begin n_bad++; $display("FAIL good_mask: got %h want c0", o_mask); end
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL good_words_left: got %0d want 0", exp_q.size()); end
        idle(5);
        @(negedge clk);
        n_cmp += 2;
        if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL good_hold_valid: got %b want 1", o_frame_valid); end
        if (o_word_count !== 5'd12) begin n_bad++; $display("FAIL good_hold_count: got %0d want 12", o_word_count); end
        release_frame();
        @(negedge clk);
        n_cmp++;
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL good_release: got %b want 0", o_frame_valid); end
        $display("good frame: 12 words played and released");
    endtask

    task automatic test_bad_frame();
        clear_cnt = 0; proc_cnt = 0;
        send_frame(5, 8'hFF, 1'b1, 1'b0, 1'b0);
        exp_drop++;
        idle(6);
        @(negedge clk);
        n_cmp += 4;
        if (clear_cnt !== 0) begin n_bad++; $display("FAIL bad_clear: got %0d want 0", clear_cnt); end
        if (proc_cnt !== 0) begin n_bad++; $display("FAIL bad_process: got %0d want 0", proc_cnt); end
        if (o_drop_count !== exp_drop) begin n_bad++; $display("FAIL bad_drop_count: got %0d want %0d", o_drop_count, exp_drop); end
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL bad_frame_valid: got %b want 0", o_frame_valid); end
        $display("bad frame: drop count now %0d", exp_drop);
    endtask

    task automatic test_overflow();
        bit ok;
        send_frame(17, 8'hFF, 1'b0, 1'b0, 1'b0);
        exp_drop++;
        idle(3);
        @(negedge clk);
        n_cmp += 2;
        if (o_drop_count !== exp_drop) begin n_bad++; $display("FAIL ovf_drop_count: got %0d want %0d", o_drop_count, exp_drop); end
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_frame_valid: got %b want 0", o_frame_valid); end
        clear_cnt = 0; proc_cnt = 0;
        send_frame(3, 8'h80, 1'b0, 1'b1, 1'b0);
        wait_hold(ok);
        n_cmp += 4;
        if (!ok) begin n_bad++; $display("FAIL ovf_next_timeout: got no frame_valid want frame_valid"); end
        if (proc_cnt !== 3) begin n_bad++; $display("FAIL ovf_next_process: got %0d want 3", proc_cnt); end
        if (o_word_count !== 5'd3) begin n_bad++; $display("FAIL ovf_next_count: got %0d want 3", o_word_count); end
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL ovf_next_left: got %0d want 0", exp_q.size()); end
        release_frame();
        proc_cnt = 0;
        send_frame(16, 8'h01, 1'b0, 1'b1, 1'b1);
        wait_hold(ok);
        n_cmp += 4;
        if (!ok) begin n_bad++; $display("FAIL full_timeout: got no frame_valid want frame_valid"); end
        if (proc_cnt !== 16) begin n_bad++; $display("FAIL full_process: got %0d want 16", proc_cnt); end
        if (o_word_count !== 5'd16) begin n_bad++; $display("FAIL full_count: got %0d want 16", o_word_count); end
        if (o_drop_count !== exp_drop) begin n_bad++; $display("FAIL full_drop_count: got %0d want %0d", o_drop_count, exp_drop); end
        release_frame();
        $display("overflow: 17-beat dropped, 3-beat and 16-beat frames played");
    endtask

    task automatic test_hold_intrusion();
        bit ok;
        logic [63:0] held_word;
        proc_cnt = 0;
        send_frame(4, 8'h3C, 1'b0, 1'b1, 1'b0);
        held_word = last_sent;
        wait_hold(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL hold_timeout: got no frame_valid want frame_valid"); end
        send_frame(3, 8'hFF, 1'b0, 1'b0, 1'b0);
        exp_drop++;
        @(negedge clk);
        n_cmp += 6;
        if (o_drop_count !== exp_drop) begin n_bad++; $display("FAIL hold_drop_count: got %0d want %0d", o_drop_count, exp_drop); end
        if (o_word_count !== 5'd4) begin n_bad++; $display("FAIL hold_count: got %0d want 4", o_word_count); end
        if (o_mask !== 8'h3C) begin n_bad++; $display("FAIL hold_mask: got %h want 3c", o_mask); end
        if (o_data !== held_word) begin n_bad++; $display("FAIL hold_data: got %h want %h", o_data, held_word); end
        if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid: got %b want 1", o_frame_valid); end
        if (proc_cnt !== 4) begin n_bad++; $display("FAIL hold_process: got %0d want 4", proc_cnt); end
        release_frame();
        proc_cnt = 0;
        send_frame(2, 8'hF0, 1'b0, 1'b1, 1'b0);
        wait_hold(ok);
        n_cmp += 3;
        if (!ok) begin n_bad++; $display("FAIL hold_next_timeout: got no frame_valid want frame_valid"); end
        if (o_word_count !== 5'd2) begin n_bad++; $display("FAIL hold_next_count: got %0d want 2", o_word_count); end
        if (proc_cnt !== 2) begin n_bad++; $display("FAIL hold_next_process: got %0d want 2", proc_cnt); end
        release_frame();
        $display("hold intrusion: foreign frame dropped, held frame intact");
    endtask

    task automatic test_single_beat();
        bit ok;
        clear_cnt = 0; proc_cnt = 0;
        release_i = 1'b1;           // release outside HOLD must have no effect
        send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
        release_i = 1'b0;
        wait_hold(ok);
        n_cmp += 5;
        if (!ok) begin n_bad++; $display("FAIL single_timeout: got no frame_valid want frame_valid"); end
        if (o_word_count !== 5'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", o_word_count); end
        if (proc_cnt !== 1) begin n_bad++; $display("FAIL single_process: got %0d want 1", proc_cnt); end
        if (clear_cnt !== 1) begin n_bad++; $display("FAIL single_clear: got %0d want 1", clear_cnt); end
        if (o_mask !== 8'h07) begin n_bad++; $display("FAIL single_mask: got %h want 07", o_mask); end
        release_frame();
        $display("single beat: one word played");
    endtask

    task automatic test_reset_mid_playout();
        bit ok;
        bit seen;
        send_frame(10, 8'hFF, 1'b0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (o_process) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL midrst_timeout: got no process want process"); end
        areset = 1'b1;
        #1;
        exp_drop = '0;
        n_cmp += 7;
        if (o_process !== 1'b0) begin n_bad++; $display("FAIL midrst_process: got %b want 0", o_process); end
        if (o_clear !== 1'b0) begin n_bad++; $display("FAIL midrst_clear: got %b want 0", o_clear); end
        if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", o_frame_valid); end
        if (o_data !== 64'h0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", o_data); end
        if (o_mask !== 8'h0) begin n_bad++; $display("FAIL midrst_mask: got %h want 0", o_mask); end
        if (o_word_count !== '0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", o_word_count); end
        if (o_drop_count !== exp_drop) begin n_bad++; $display("FAIL midrst_drop: got %0d want 0", o_drop_count); end
        exp_q.delete();
        @(posedge clk); #1;
        areset = 1'b0;
        idle(2);
        proc_cnt = 0;
        send_frame(5, 8'hE0, 1'b0, 1'b1, 1'b1);
        wait_hold(ok);
        n_cmp += 5;
        if (!ok) begin n_bad++; $display("FAIL midrst_next_timeout: got no frame_valid want frame_valid"); end
        if (proc_cnt !== 5) begin n_bad++; $display("FAIL midrst_next_process: got %0d want 5", proc_cnt); end
        if (o_word_count !== 5'd5) begin n_bad++; $display("FAIL midrst_next_count: got %0d want 5", o_word_count); end
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL midrst_next_left: got %0d want 0", exp_q.size()); end
        if (o_drop_count !== exp_drop) begin n_bad++; $display("FAIL midrst_next_drop: got %0d want 0", o_drop_count); end
        release_frame();
        $display("reset mid-playout: outputs cleared, next frame played");
    endtask

    initial begin
        areset    = 1'b1;
        mac_valid = 1'b0;
        mac_data  = '0;
        mac_last  = 1'b0;
        mac_bytes = '0;
        mac_bad   = 1'b0;
        release_i = 1'b0;

        // Scoreboard: each process strobe must match the word shown one cycle earlier.
        fork
            forever begin
                logic [63:0] exp_w;
                @(negedge clk);
                if (o_clear) clear_cnt++;
                if (o_process) begin
                    proc_cnt++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_underflow: got process with data %h want no process", o_data);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (prev_data !== exp_w) begin
                            n_bad++;
                            $display("FAIL sb_word: got %h want %h", prev_data, exp_w);
                        end
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            if (o_data !== exp_w) begin
                                n_bad++;
                                $display("FAIL sb_final_hold: got %h want %h", o_data, exp_w);
                            end
                        end
                    end
                end
                prev_data = o_data;
            end
        join_none

        test_reset();
        test_good_frame();
        test_bad_frame();
        test_overflow();
        test_hold_intrusion();
        test_single_beat();
        test_reset_mid_playout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nts_rx_sequencer.md
NTS_RX_SEQUENCER -- requirements
Module: nts_rx_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving log2 of buffer depth in 64-bit words.
REQ-002 SHALL have port i_clk, input, 1, clock; all state changes on rising edge.
REQ-003 SHALL have port i_areset, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port i_mac_valid, input, 1, MAC receive beat valid.
REQ-005 SHALL have port i_mac_data, input, 64, MAC receive word, first byte in [63:56].
REQ-006 SHALL have port i_mac_last, input, 1, final beat of frame, qualified by i_mac_valid.
REQ-007 SHALL have port i_mac_bytes_valid, input, 8, byte-valid mask of final beat, qualified by i_mac_last.
REQ-008 SHALL have port i_mac_bad, input, 1, MAC error on final beat (FCS/PHY), qualified by i_mac_last.
REQ-009 SHALL have port i_release, input, 1, downstream done with current frame.
REQ-010 SHALL have ports o_clear (1), o_process (1), o_data (64) and o_last_word_data_valid (8), all outputs, forming the parser drive bus.
REQ-011 SHALL have port o_frame_valid, output, 1, playout of the complete frame has finished.
REQ-012 SHALL have port o_word_count, output, ADDR_WIDTH+1, number of words in the held frame.
REQ-013 SHALL have port o_drop_count, output, 32, running count of discarded frames.

Function
REQ-014 SHALL implement states IDLE, RECEIVE, DROP, CLEAR, PLAYOUT, HOLD.
REQ-015 IDLE: on i_mac_valid, SHALL write the beat to buffer address 0, set the count to 1, and enter RECEIVE; if i_mac_last is also high, SHALL go to CLEAR (or DROP-accounting when i_mac_bad).
REQ-016 RECEIVE: each valid beat SHALL be written at the next address; non-valid cycles SHALL cause no writes.
REQ-017 A frame whose beat count exceeds 2^ADDR_WIDTH SHALL be discarded: enter DROP, stop writing, no address wrap-around.
REQ-018 A last beat with i_mac_bad=1 SHALL discard the frame, increment o_drop_count, and return to IDLE.
REQ-019 DROP SHALL ignore beats until a valid i_mac_last, then increment o_drop_count once and enter IDLE.
REQ-020 A good last beat SHALL latch i_mac_bytes_valid into o_last_word_data_valid and enter CLEAR.
REQ-021 CLEAR SHALL assert o_clear for exactly one cycle and start the synchronous buffer read of word 0.
REQ-022 PLAYOUT SHALL present word k on o_data in cycle T0+k and assert o_process in cycles T0+1..T0+N; o_data SHALL lead o_process by one cycle (N = o_word_count).
REQ-023 o_data SHALL hold word N-1 during the final o_process cycle; o_process SHALL deassert afterwards.
REQ-024 HOLD SHALL assert o_frame_valid and keep o_word_count and o_last_word_data_valid stable until i_release, then enter IDLE next cycle.
REQ-025 MAC beats arriving in CLEAR, PLAYOUT or HOLD SHALL be discarded, and o_drop_count SHALL increment once per such frame at its last beat.
REQ-026 o_drop_count SHALL wrap modulo 2^32.
REQ-027 i_release outside HOLD SHALL be ignored.

Reset
REQ-028 On i_areset, all state SHALL clear immediately: state IDLE; o_clear, o_process, o_frame_valid, o_data, o_last_word_data_valid, o_word_count and o_drop_count all 0.
REQ-029 Reset mid-frame or mid-playout SHALL abandon the frame without counting it; buffer contents are undefined.

Verification
REQ-030 12-beat good frame, last mask 8'hC0 -> o_clear 1 cycle; o_process high 12 cycles, each one cycle after matching o_data; o_word_count=12; o_last_word_data_valid=8'hC0; o_frame_valid until i_release.
REQ-031 Frame with i_mac_bad on last beat -> no o_clear/o_process; o_drop_count 0->1; state IDLE.
REQ-032 ADDR_WIDTH=4, 17-beat frame -> dropped, o_drop_count=1; a following 3-beat frame plays out correctly.
REQ-033 Second frame sent during HOLD -> o_drop_count +1; held frame outputs unchanged; after i_release, a next frame is accepted.
REQ-034 Single-beat frame (valid+last same cycle) -> o_word_count=1, one o_process pulse.
REQ-035 i_areset asserted mid-PLAYOUT -> outputs 0 at once; o_drop_count=0; a new frame after reset plays out normally.
